// File: rtl/pass_pkg.sv
// rtl/pass_pkg.sv - shared types and constants for the password entry front end
package pass_pkg;

  localparam int         CODE_W    = 16;
  localparam int         DIGITS    = 4;
  localparam logic [3:0] KEY_CLEAR = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK1,
    S_CHECK2,
    S_VERDICT,
    S_OPEN,
    S_NEWPW,
    S_COMMIT,
    S_LOCKOUT
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - lockout down-counter, done flags the last lockout cycle
module lock_timer #(
  parameter int LOCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int            CW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOCK_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loaded with LOCK_CYCLES on entry, so the count of 1 is the final lockout cycle.
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/pass_entry.sv
// rtl/pass_entry.sv - keypad code collection, verify/change sequencing and lockout
module pass_entry
  import pass_pkg::*;
#(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              enter,
  input  logic              change_req,
  input  logic              lock_req,
  input  logic              right,
  input  logic              error,
  output logic [CODE_W-1:0] password,
  output logic              confirmPass,
  output logic              changePass,
  output logic [2:0]        digit_cnt,
  output logic              unlocked,
  output logic              alarm
);

  state_t            state, next_state;
  logic [CODE_W-1:0] buf_next;
  logic [2:0]        cnt_next;
  logic [3:0]        fail_cnt, fail_next;
  logic              timer_load, lock_done;
  logic              do_lock, do_enter, do_change, do_key, full;

  // Only the highest-priority strobe of a cycle is acted upon.
  assign do_lock   = lock_req;
  assign do_enter  = !lock_req && enter;
  assign do_change = !lock_req && !enter && change_req;
  assign do_key    = !lock_req && !enter && !change_req && key_valid;
  assign full      = (digit_cnt == 3'(DIGITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      password  <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      state     <= next_state;
      password  <= buf_next;
      digit_cnt <= cnt_next;
      fail_cnt  <= fail_next;
    end
  end

  always_comb begin
    next_state = state;
    buf_next   = password;
    cnt_next   = digit_cnt;
    fail_next  = fail_cnt;
    case (state)
      S_IDLE, S_NEWPW: begin
        if (state == S_NEWPW && do_lock) begin
          next_state = S_IDLE;
          buf_next   = '0;
          cnt_next   = '0;
        end else if (do_enter && full) begin
          next_state = (state == S_IDLE) ? S_CHECK1 : S_COMMIT;
        end else if (do_key) begin
          if (key_code == KEY_CLEAR) begin
            buf_next = '0;
            cnt_next = '0;
          end else if (is_digit(key_code) && !full) begin
            buf_next = {password[CODE_W-5:0], key_code};
            cnt_next = digit_cnt + 3'd1;
          end
        end
      end
      S_CHECK1:  next_state = S_CHECK2;
      S_CHECK2:  next_state = S_VERDICT;
      S_VERDICT: begin
        buf_next = '0;
        cnt_next = '0;
        if (right && !error) begin
          next_state = S_OPEN;
          fail_next  = '0;
        end else begin
          if (fail_cnt < 4'(MAX_TRIES)) fail_next = fail_cnt + 4'd1;
          next_state = (fail_next >= 4'(MAX_TRIES)) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_OPEN: begin
        if (do_lock) begin
          next_state = S_IDLE;
        end else if (do_change) begin
          next_state = S_NEWPW;
          buf_next   = '0;
          cnt_next   = '0;
        end
      end
      S_COMMIT: begin
        next_state = S_OPEN;
        buf_next   = '0;
        cnt_next   = '0;
      end
      S_LOCKOUT: begin
        if (lock_done) begin
          next_state = S_IDLE;
          fail_next  = '0;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign timer_load = (next_state == S_LOCKOUT) && (state != S_LOCKOUT);

  lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (lock_done)
  );

  assign confirmPass = (state == S_CHECK1) || (state == S_CHECK2);
  assign changePass  = (state == S_COMMIT);
  assign unlocked    = (state == S_OPEN) || (state == S_NEWPW) || (state == S_COMMIT);
  assign alarm       = (state == S_LOCKOUT);

endmodule

// File: tb/tb_pass_entry.sv
// tb/tb_pass_entry.sv - randomized and directed checks of pass_entry against a transaction model
module tb_pass_entry;

  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 1000;
  localparam int M_IDLE = 0, M_OPEN = 1, M_NEWPW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        enter = 1'b0;
  logic        change_req = 1'b0;
  logic        lock_req = 1'b0;
  logic        right, error;
  logic [15:0] password;
  logic        confirmPass, changePass, unlocked, alarm;
  logic [2:0]  digit_cnt;

  pass_entry #(.MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .enter(enter), .change_req(change_req), .lock_req(lock_req),
    .right(right), .error(error), .password(password),
    .confirmPass(confirmPass), .changePass(changePass), .digit_cnt(digit_cnt),
    .unlocked(unlocked), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Password checker stand-in: stores on changePass, verdict from the last confirm cycle.
  logic [15:0] chk_code;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_code <= 16'h1874;
      right    <= 1'b0;
      error    <= 1'b0;
    end else if (confirmPass) begin
      right <= (password == chk_code);
      error <= (password != chk_code);
    end else if (changePass) begin
      chk_code <= password;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_buf;
  int          m_cnt, m_mode, m_fail;
  logic [15:0] m_code;
  bit          m_alarm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_buf = 16'h0; m_cnt = 0; m_mode = M_IDLE; m_fail = 0; m_code = 16'h1874; m_alarm = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "/password"}, password, m_buf);
    check({tag, "/digit_cnt"}, digit_cnt, m_cnt);
    check({tag, "/unlocked"}, unlocked, m_mode != M_IDLE);
    check({tag, "/alarm"}, alarm, m_alarm);
    check({tag, "/confirm"}, confirmPass, 0);
    check({tag, "/change"}, changePass, 0);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    tick();
    key_valid = 1'b0;
    if (m_mode != M_OPEN) begin
      if (k == 4'hA) begin
        m_buf = 16'h0; m_cnt = 0;
      end else if (k <= 4'd9 && m_cnt < 4) begin
        m_buf = {m_buf[11:0], k}; m_cnt++;
      end
    end
    check_state("key");
  endtask

  task automatic type_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic run_lockout();
    int n_alarm, n_conf;
    n_alarm = 0; n_conf = 0;
    for (int i = 0; i < 3 * LOCK_CYCLES; i++) begin
      if (!alarm) break;
      n_alarm++;
      n_conf += int'(confirmPass) + int'(unlocked);
      enter = 1'($urandom_range(0, 1));
      key_valid = 1'($urandom_range(0, 1));
      key_code = 4'($urandom_range(0, 9));
      tick();
    end
    enter = 1'b0; key_valid = 1'b0;
    check("lockout_len", n_alarm, LOCK_CYCLES);
    check("lockout_quiet", n_conf, 0);
    m_alarm = 0; m_fail = 0;
    check_state("after_lock");
  endtask

  task automatic do_enter(input bit with_key, input logic [3:0] k);
    int n_conf;
    logic [15:0] sub;
    enter = 1'b1; key_valid = with_key; key_code = k;
    tick();
    enter = 1'b0; key_valid = 1'b0;
    if (m_mode == M_IDLE && m_cnt == 4) begin
      n_conf = 0;
      for (int i = 0; i < 3; i++) begin
        n_conf += int'(confirmPass);
        check("hold_pw", password, m_buf);
        tick();
      end
      check("confirm_cycles", n_conf, 2);
      sub = m_buf; m_buf = 16'h0; m_cnt = 0;
      if (sub == m_code) begin
        m_mode = M_OPEN; m_fail = 0;
      end else begin
        if (m_fail < MAX_TRIES) m_fail++;
        if (m_fail >= MAX_TRIES) m_alarm = 1;
      end
      check_state("verdict");
      if (m_alarm) run_lockout();
    end else if (m_mode == M_NEWPW && m_cnt == 4) begin
      check("commit_pulse", changePass, 1);
      check("commit_pw", password, m_buf);
      check("commit_conf", confirmPass, 0);
      tick();
      m_code = m_buf; m_buf = 16'h0; m_cnt = 0; m_mode = M_OPEN;
      check_state("commit");
    end else begin
      check_state("enter_ignored");
    end
  endtask

  task automatic do_lock(input bit with_enter);
    lock_req = 1'b1; enter = with_enter;
    tick();
    lock_req = 1'b0; enter = 1'b0;
    if (m_mode != M_IDLE) begin
      m_mode = M_IDLE; m_buf = 16'h0; m_cnt = 0;
    end
    check_state("lock");
  endtask

  task automatic do_change();
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    if (m_mode == M_OPEN) begin
      m_mode = M_NEWPW; m_buf = 16'h0; m_cnt = 0;
    end
    check_state("change");
  endtask

  task automatic go_idle();
    if (m_mode != M_IDLE) do_lock(1'b0);
    press(4'hA);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b1;
    tick();

    // Default code unlocks
    type_code(16'h1874);
    do_enter(1'b0, 4'h0);
    check("unlock_default", unlocked, 1);
    do_lock(1'b0);

    // Three wrong codes lock out
    for (int i = 0; i < 3; i++) begin
      type_code(16'h1234);
      do_enter(1'b0, 4'h0);
    end

    // Partial entry, clear, overflow digit dropped
    press(4'h5); press(4'h5);
    do_enter(1'b0, 4'h0);
    press(4'hA);
    type_code(16'h1234);
    press(4'h9);
    check("overflow_buf", password, 16'h1234);
    press(4'hC);
    press(4'hA);

    // Change password flow
    type_code(16'h1874);
    do_enter(1'b0, 4'h0);
    do_change();
    type_code(16'h9012);
    do_enter(1'b0, 4'h0);
    do_lock(1'b0);
    type_code(16'h9012);
    do_enter(1'b0, 4'h0);
    check("unlock_new", unlocked, 1);
    do_lock(1'b0);
    type_code(16'h1874);
    do_enter(1'b0, 4'h0);
    check("old_code_rejected", unlocked, 0);

    // Same-cycle strobes
    type_code(16'h9012);
    do_enter(1'b1, 4'h5);
    do_change();
    type_code(16'h4321);
    do_lock(1'b1);
    check("lock_beats_enter", changePass, 0);

    // Reset during CHECK2
    type_code(16'h9012);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    check("in_check2", confirmPass, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_state("mid_reset");
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    check_state("post_reset");
    type_code(16'h1874);
    do_enter(1'b0, 4'h0);
    check("unlock_after_reset", unlocked, 1);
    go_idle();

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50)       press(4'($urandom_range(0, 9)));
      else if (r < 55)  press(4'hA);
      else if (r < 58)  press(4'($urandom_range(11, 15)));
      else if (r < 68)  do_enter(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
      else if (r < 78) begin
        press(4'hA);
        type_code(m_code);
        do_enter(1'b0, 4'h0);
      end
      else if (r < 88)  do_lock(1'($urandom_range(0, 1)));
      else              do_change();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
